shift_unit: RTL and testbench
=============================

# shift_unit

Multicycle LC-3b shift unit executing SHF (LSHF, RSHFL, RSHFA). It sits beside the ALU in the datapath, takes the same SR1 operand, and feeds the same result mux toward the register file and CC logic. It shifts iteratively (STEP bit positions per cycle) under a start/done handshake with the control FSM. It also produces the NZP code of its result.

## Interface

- STEP, default 1: maximum bit positions shifted per cycle; legal values 1, 2, 4, 8, 16; any other value fails elaboration.
- clk  in  1  clock, rising-edge.
- reset_n  in  1  reset, asynchronous and active-low.
- start  in  1  request; sampled only in IDLE.
- shiftop  in  lc3b_shiftop (2)  {A,D} from IR[5:4].
- a  in  lc3b_word (16)  operand to shift.
- amount  in  lc3b_imm4 (4)  shift count, 0–15, from IR[3:0].
- busy  out  1  high while an accepted operation is in flight, including the done cycle.
- done  out  1  one-cycle pulse; f and cc are valid and updated.
- f  out  lc3b_word (16)  result register.
- cc  out  lc3b_nzp (3)  {n,z,p} of f, registered with f.

## Operation

- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 captures a into the working register, and captures shiftop and amount into rem.
  - Transition to DONE if amount==0, else to SHIFT.
  - start=0 stays in IDLE.
- SHIFT:
  - Each cycle, shift the working register by k = min(STEP, rem), then rem -= k.
  - Transition to DONE on the edge where rem becomes 0.
- DONE:
  - done=1 for exactly one cycle, then back to IDLE.
  - f and cc load from the working register on the edge entering DONE.
- Shift semantics (D selects direction; A matters only when D=1):
  - D=0: logical left, zero fill. Encoding 2'b10 therefore behaves as LSHF.
  - {A,D}=01: logical right, zero fill.
  - {A,D}=11: arithmetic right, fill with captured a[15].
- cc rules:
  - n = f[15].
  - z = (f==0).
  - p = !n && !z.
  - Exactly one bit is set.
- f and cc hold their value from the last completed operation until the next DONE entry. Intermediate shift values never appear on f.
- Reset (asynchronous, any state, including mid-shift):
  - state=IDLE, busy=0, done=0, f=16'h0000, cc=3'b010, rem=0.
  - An aborted operation never produces done.
- start while busy (SHIFT or DONE cycle): ignored; inputs are not sampled. The control FSM waits for done, then re-asserts start in a later cycle.
- a, shiftop and amount need only be stable in the cycle start is sampled.

## Timing

- Let E0 be the rising edge at which start is sampled in IDLE. Let L = ceil(amount/STEP).
- busy goes high after E0 and falls after the done cycle.
- done is high during the cycle beginning at edge E0+L. For amount=0, that is the cycle right after E0.
- f and cc change at edge E0+L only.
- IDLE is re-entered at E0+L+1. The earliest next accepted start is sampled at E0+L+1.
- Worst case, STEP=1, amount=15: done in the cycle after E0+15, next start accepted at E0+16.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure

- Add to lc3b_types:
  - lc3b_shiftop enum: shf_lsl=2'b00, shf_lsr=2'b01, shf_asr=2'b11.
  - lc3b_imm4: logic [3:0].
  - lc3b_nzp: logic [2:0].
- The state enum stays local to shift_unit.
- One combinational sub-module, shift_step:
  - Inputs: word, direction, arith flag, k (0..STEP).
  - Output: shifted word.
  - Instantiated once per shift_unit.
- The FSM, the rem counter and the f/cc registers live in shift_unit.

## Test plan

1. STEP=1, LSHF, a=16'h0001, amount=4 -> done in cycle after E0+4; f=16'h0010, cc=001; busy high for 5 cycles.
2. STEP=1, RSHFA, a=16'h8000, amount=15 -> f=16'hFFFF, cc=100. Same operands with RSHFL -> f=16'h0001, cc=001.
3. amount=0, a=16'h1234 -> done in cycle after E0, f=16'h1234, cc=001. shiftop=2'b10, a=16'h4000, amount=1 -> f=16'h8000, cc=100.
4. Start STEP=1 LSHF a=16'h00FF amount=8. At E0+2 assert start with a=16'hFFFF amount=1 -> ignored; done after E0+8, f=16'hFF00, cc=100. Then LSHF a=16'h0000 amount=3 -> f=16'h0000, cc=010.
5. Start amount=8; drive reset_n low between E0+3 and E0+4 -> busy=0, f=0, cc=010 without waiting for an edge; no done ever follows; a fresh start after release completes normally.
6. STEP=4, RSHFL, a=16'hF000, amount=7 -> done in cycle after E0+2; f=16'h01E0, cc=001.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types used by the shift unit and its neighbours.
// Also holds the NZP helper that the unit applies to its result.
package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [3:0]  lc3b_imm4;
   typedef logic [2:0]  lc3b_nzp;

   // {A,D} as decoded from IR[5:4]; 2'b10 is not listed but shifts left
   typedef enum logic [1:0] {
      shf_lsl = 2'b00,
      shf_lsr = 2'b01,
      shf_asr = 2'b11
   } lc3b_shiftop;

   localparam lc3b_nzp NZP_ZERO = 3'b010;

   function automatic lc3b_nzp nzp_of(input lc3b_word w);
      logic n, z;
      n = w[15];
      z = (w == 16'h0000);
      return {n, z, !n && !z};
   endfunction

endpackage

// File: rtl/shift_unit_step.sv
// One combinational shift of up to STEP positions; k=0 passes the word through.
// An arithmetic right shift keeps bit 15 unchanged, so it is always the fill bit.
module shift_step
   import lc3b_types::*;
#(
   parameter int KW = 1
) (
   input  logic [15:0]   word,
   input  logic          dir_right,
   input  logic          arith,
   input  logic [KW-1:0] k,
   output logic [15:0]   shifted
);

   always_comb begin
      shifted = word;
      if (!dir_right) begin
         shifted = word << k;
      end else if (arith) begin
         shifted = 16'($signed(word) >>> k);
      end else begin
         shifted = word >> k;
      end
   end

endmodule

// File: rtl/shift_unit.sv
// Multicycle LC-3b SHF unit: shifts up to STEP bits per cycle under a start/done
// handshake and registers the result with its NZP code.
module shift_unit
   import lc3b_types::*;
#(
   parameter int STEP = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [1:0]  shiftop,
   input  logic [15:0] a,
   input  logic [3:0]  amount,
   output logic        busy,
   output logic        done,
   output logic [15:0] f,
   output logic [2:0]  cc
);

   localparam int KW = $clog2(STEP + 1);

   if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8 || STEP == 16)) begin : g_bad_step
      $error("shift_unit: STEP must be 1, 2, 4, 8 or 16");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] work_q, work_d;
   logic [3:0]  rem_q, rem_d;
   logic        right_q, right_d;
   logic        arith_q, arith_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [15:0] f_q, f_d;
   logic [2:0]  cc_q, cc_d;

   logic [4:0]    k_wide;
   logic [KW-1:0] k;
   logic [3:0]    rem_next;
   logic [15:0]   shifted;

   // rem never exceeds 15, so k fits in the low 4 bits for the subtraction
   always_comb begin
      k_wide   = ({1'b0, rem_q} > 5'(STEP)) ? 5'(STEP) : {1'b0, rem_q};
      k        = k_wide[KW-1:0];
      rem_next = rem_q - k_wide[3:0];
   end

   shift_step #(.KW(KW)) u_step (
      .word      (work_q),
      .dir_right (right_q),
      .arith     (arith_q),
      .k         (k),
      .shifted   (shifted)
   );

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      rem_d   = rem_q;
      right_d = right_q;
      arith_d = arith_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      f_d     = f_q;
      cc_d    = cc_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               work_d  = a;
               rem_d   = amount;
               right_d = shiftop[0];
               arith_d = shiftop[1] & shiftop[0];
               busy_d  = 1'b1;
               if (amount == 4'd0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  f_d     = a;
                  cc_d    = nzp_of(a);
               end else begin
                  state_d = S_SHIFT;
               end
            end
         end
         S_SHIFT: begin
            work_d = shifted;
            rem_d  = rem_next;
            if (rem_next == 4'd0) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               f_d     = shifted;
               cc_d    = nzp_of(shifted);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         work_q  <= 16'h0000;
         rem_q   <= 4'd0;
         right_q <= 1'b0;
         arith_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         f_q     <= 16'h0000;
         cc_q    <= NZP_ZERO;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         rem_q   <= rem_d;
         right_q <= right_d;
         arith_q <= arith_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         f_q     <= f_d;
         cc_q    <= cc_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign f    = f_q;
   assign cc   = cc_q;

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit with STEP=1 and STEP=4 instances; expected
// results are queued when an operation is launched and popped on done.
module tb_shift_unit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start1 = 1'b0;
   logic        start4 = 1'b0;
   logic [1:0]  shiftop = 2'b00;
   logic [15:0] a = 16'h0000;
   logic [3:0]  amount = 4'd0;
   logic        busy1, done1, busy4, done4;
   logic [15:0] f1, f4;
   logic [2:0]  cc1, cc4;

   int n_chk = 0;
   int n_fail = 0;
   int sel_cur = 1;

   typedef struct {
      logic [15:0] f;
      logic [2:0]  cc;
      int          lat;
   } exp_t;
   exp_t sb[$];
   logic [15:0] last_f[2];

   logic        busy_s, done_s;
   logic [15:0] f_s;
   logic [2:0]  cc_s;
   assign busy_s = (sel_cur == 4) ? busy4 : busy1;
   assign done_s = (sel_cur == 4) ? done4 : done1;
   assign f_s    = (sel_cur == 4) ? f4    : f1;
   assign cc_s   = (sel_cur == 4) ? cc4   : cc1;

   shift_unit #(.STEP(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .start(start1), .shiftop(shiftop), .a(a),
      .amount(amount), .busy(busy1), .done(done1), .f(f1), .cc(cc1)
   );

   shift_unit #(.STEP(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .start(start4), .shiftop(shiftop), .a(a),
      .amount(amount), .busy(busy4), .done(done4), .f(f4), .cc(cc4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model(input logic [1:0] op, input logic [15:0] v, input int amt);
      logic [15:0] r;
      r = v;
      for (int i = 0; i < amt; i++) begin
         if (op == 2'b01)      r = {1'b0, r[15:1]};
         else if (op == 2'b11) r = {v[15], r[15:1]};
         else                  r = {r[14:0], 1'b0};
      end
      return r;
   endfunction

   function automatic logic [2:0] model_cc(input logic [15:0] v);
      if (v[15])          return 3'b100;
      if (v == 16'h0000)  return 3'b010;
      return 3'b001;
   endfunction

   // inj >= 0 re-asserts start (with other operands) inj cycles into the op
   task automatic run_op(input int sel, input logic [1:0] op, input logic [15:0] av,
                         input logic [3:0] amt, input int inj);
      exp_t e;
      int   n;
      int   idx;
      bit   got;
      idx     = (sel == 4) ? 1 : 0;
      sel_cur = sel;
      e.f     = model(op, av, int'(amt));
      e.cc    = model_cc(e.f);
      e.lat   = (int'(amt) + sel - 1) / sel;
      sb.push_back(e);
      @(negedge clk);
      shiftop = op; a = av; amount = amt;
      if (sel == 4) start4 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; start4 = 1'b0;
      a = 16'($urandom); amount = 4'($urandom); shiftop = 2'($urandom);
      n = 0; got = 1'b0;
      while (!got && n < 40) begin
         if (n == inj) begin
            shiftop = 2'b00; a = 16'hFFFF; amount = 4'd1;
            if (sel == 4) start4 = 1'b1; else start1 = 1'b1;
         end else begin
            start1 = 1'b0; start4 = 1'b0;
         end
         chk("busy_in_flight", 32'(busy_s), 32'd1);
         if (done_s) begin
            got = 1'b1;
            e = sb.pop_front();
            chk("latency", n, e.lat);
            chk("f", 32'(f_s), 32'(e.f));
            chk("cc", 32'(cc_s), 32'(e.cc));
            last_f[idx] = e.f;
         end else begin
            chk("f_hold", 32'(f_s), 32'(last_f[idx]));
            @(negedge clk);
            n++;
         end
      end
      start1 = 1'b0; start4 = 1'b0;
      if (!got) begin
         chk("done_timeout", 32'd0, 32'd1);
         void'(sb.pop_front());
      end else begin
         @(negedge clk);
         chk("busy_after_done", 32'(busy_s), 32'd0);
         chk("done_one_cycle", 32'(done_s), 32'd0);
         chk("f_after_done", 32'(f_s), 32'(last_f[idx]));
      end
   endtask

   initial begin
      bit saw_done;
      last_f[0] = 16'h0000;
      last_f[1] = 16'h0000;
      repeat (2) @(negedge clk);
      chk("rst_busy1", 32'(busy1), 32'd0);
      chk("rst_done1", 32'(done1), 32'd0);
      chk("rst_f1", 32'(f1), 32'h0000);
      chk("rst_cc1", 32'(cc1), 32'h2);
      chk("rst_f4", 32'(f4), 32'h0000);
      chk("rst_cc4", 32'(cc4), 32'h2);
      reset_n = 1'b1;

      run_op(1, 2'b00, 16'h0001, 4'd4, -1);
      run_op(1, 2'b11, 16'h8000, 4'd15, -1);
      run_op(1, 2'b01, 16'h8000, 4'd15, -1);
      run_op(1, 2'b00, 16'h1234, 4'd0, -1);
      run_op(1, 2'b10, 16'h4000, 4'd1, -1);
      run_op(1, 2'b00, 16'h00FF, 4'd8, 1);
      run_op(1, 2'b00, 16'h0000, 4'd3, -1);
      run_op(1, 2'b11, 16'h4F00, 4'd5, -1);

      // asynchronous reset in the middle of an 8-step shift
      sel_cur = 1;
      @(negedge clk);
      shiftop = 2'b00; a = 16'h00FF; amount = 4'd8; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy1), 32'd0);
      chk("abort_done", 32'(done1), 32'd0);
      chk("abort_f", 32'(f1), 32'h0000);
      chk("abort_cc", 32'(cc1), 32'h2);
      last_f[0] = 16'h0000;
      last_f[1] = 16'h0000;
      @(negedge clk);
      reset_n = 1'b1;
      saw_done = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done1 || busy1) saw_done = 1'b1;
      end
      chk("abort_no_done", 32'(saw_done), 32'd0);
      run_op(1, 2'b01, 16'hABCD, 4'd2, -1);

      run_op(4, 2'b01, 16'hF000, 4'd7, -1);
      run_op(4, 2'b11, 16'h8000, 4'd15, -1);
      run_op(4, 2'b00, 16'h0F0F, 4'd4, -1);
      run_op(4, 2'b00, 16'h5555, 4'd0, -1);
      run_op(4, 2'b11, 16'h7FFF, 4'd13, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
